// File: rtl/serial_subtractor_nibble_if.sv
// Operand/result bundle for serial_subtractor_nibble.
// Z and N exist only when SUBNIB_FLAGS_EN is defined.
interface serial_subtractor_nibble_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] D;
    logic             Bout;
`ifdef SUBNIB_FLAGS_EN
    logic             Z;
    logic             N;
`endif

    modport master (
        output start, A, B, Bin,
`ifdef SUBNIB_FLAGS_EN
        input  Z, N,
`endif
        input  busy, done, D, Bout
    );

    modport slave (
        input  start, A, B, Bin,
`ifdef SUBNIB_FLAGS_EN
        output Z, N,
`endif
        output busy, done, D, Bout
    );
endinterface

// File: rtl/serial_subtractor_nibble.sv
// Nibble-serial D = A - B - Bin over a 4-bit ripple subtractor.
// Optional Z/N flag outputs enabled by SUBNIB_FLAGS_EN.
module full_subtractor_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       bin,
    output logic [3:0] d,
    output logic       bout
);
    logic c;

    always_comb begin
        d = '0;
        c = bin;
        for (int i = 0; i < 4; i++) begin
            d[i] = a[i] ^ b[i] ^ c;
            c    = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & c);
        end
        bout = c;
    end
endmodule

module serial_subtractor_nibble #(
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    serial_subtractor_nibble_if.slave bus
);
    localparam int NIB = WIDTH / 4;
    localparam int CW  = $clog2(NIB);
    localparam logic [CW-1:0] LAST = CW'(NIB - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] d_q;
    logic [WIDTH-1:0] d_nxt;
    logic             brw_q;
    logic             bout_q;
    logic [3:0]       nib_d;
    logic             nib_bo;
    logic             accept;
    logic             last;
`ifdef SUBNIB_FLAGS_EN
    logic             z_q;
    logic             n_q;
`endif

    assign accept = bus.start &&
                    (state_q == IDLE || state_q == DONE);
    assign last   = (state_q == RUN) && (cnt_q == LAST);

    full_subtractor_4bit u_fs (
        .a    (a_q[4*cnt_q +: 4]),
        .b    (b_q[4*cnt_q +: 4]),
        .bin  (brw_q),
        .d    (nib_d),
        .bout (nib_bo)
    );

    // Full result including the nibble being written this cycle,
    // so flags can be registered on the same edge as Bout.
    always_comb begin
        d_nxt              = d_q;
        d_nxt[4*cnt_q +: 4] = nib_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.start) state_d = RUN;
            RUN:     if (cnt_q == LAST) state_d = DONE;
            DONE:    state_d = bus.start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            a_q    <= '0;
            b_q    <= '0;
            d_q    <= '0;
            brw_q  <= 1'b0;
            bout_q <= 1'b0;
`ifdef SUBNIB_FLAGS_EN
            z_q    <= 1'b0;
            n_q    <= 1'b0;
`endif
        end else if (accept) begin
            cnt_q  <= '0;
            a_q    <= bus.A;
            b_q    <= bus.B;
            d_q    <= '0;
            brw_q  <= bus.Bin;
            bout_q <= 1'b0;
`ifdef SUBNIB_FLAGS_EN
            z_q    <= 1'b0;
            n_q    <= 1'b0;
`endif
        end else if (state_q == RUN) begin
            d_q   <= d_nxt;
            brw_q <= nib_bo;
            cnt_q <= last ? '0 : cnt_q + 1'b1;
            if (last) begin
                bout_q <= nib_bo;
`ifdef SUBNIB_FLAGS_EN
                z_q    <= (d_nxt == '0);
                n_q    <= d_nxt[WIDTH-1];
`endif
            end
        end
    end

    assign bus.busy = (state_q == RUN);
    assign bus.done = (state_q == DONE);
    assign bus.D    = d_q;
    assign bus.Bout = bout_q;
`ifdef SUBNIB_FLAGS_EN
    assign bus.Z    = z_q;
    assign bus.N    = n_q;
`endif
endmodule

// File: tb/tb_serial_subtractor_nibble.sv
// Scoreboard bench for serial_subtractor_nibble, WIDTH=16.
// Flag checks compile in when SUBNIB_FLAGS_EN is defined.
module tb_serial_subtractor_nibble;
    typedef struct {
        logic [15:0] d;
        logic        bo;
        logic        z;
        logic        n;
        int          cyc;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    exp_t q[$];
    exp_t e;

    serial_subtractor_nibble_if #(.WIDTH(16)) bus ();

    serial_subtractor_nibble #(.WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string nm, logic [31:0] act,
                       logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h",
                     nm, act, req);
        end
    endtask

    // Monitor: each done pulse pops one expected result.
    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done at cyc=%0d", cyc);
            end else begin
                e = q.pop_front();
                chk({e.name, "_D"}, 32'(bus.D), 32'(e.d));
                chk({e.name, "_Bout"}, 32'(bus.Bout), 32'(e.bo));
                chk({e.name, "_cyc"}, cyc, e.cyc);
`ifdef SUBNIB_FLAGS_EN
                chk({e.name, "_Z"}, 32'(bus.Z), 32'(e.z));
                chk({e.name, "_N"}, 32'(bus.N), 32'(e.n));
`endif
            end
        end
    end

    // Accept happens at the next edge k; done seen at negedge k+4.
    task automatic issue(logic [15:0] a, logic [15:0] b,
                         logic bin, logic [15:0] d, logic bo,
                         logic z, logic n, string name,
                         bit push);
        exp_t x;
        @(negedge clk);
        bus.A     = a;
        bus.B     = b;
        bus.Bin   = bin;
        bus.start = 1'b1;
        x = '{d, bo, z, n, cyc + 5, name};
        if (push) q.push_back(x);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_idle();
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while ((bus.busy || q.size() != 0) && k < 30);
        if (k >= 30) begin
            checks++;
            errors++;
            $display("FAIL wait_idle timeout q=%0d", q.size());
        end
        @(negedge clk);
    endtask

    initial begin
        exp_t x;
        int   k1;
        bus.start = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        bus.Bin   = 1'b0;
        #12;
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_D", 32'(bus.D), 0);
        chk("rst_Bout", 32'(bus.Bout), 0);
        @(negedge clk);
        rst = 1'b0;

        issue(16'h1234, 16'h0234, 0, 16'h1000, 0, 0, 0, "v1", 1);
        wait_idle();
        issue(16'h0000, 16'h0001, 0, 16'hFFFF, 1, 0, 1, "v2", 1);
        wait_idle();
        issue(16'h8000, 16'h7FFF, 1, 16'h0000, 0, 1, 0, "v3", 1);
        wait_idle();
        issue(16'hFFFF, 16'hFFFF, 1, 16'hFFFF, 1, 0, 1, "v4", 1);
        wait_idle();

        // Start pulse in the 2nd RUN cycle must be ignored.
        issue(16'h00FF, 16'h0001, 0, 16'h00FE, 0, 0, 0, "ign", 1);
        @(negedge clk);
        bus.A     = 16'hFFFF;
        bus.B     = 16'h1111;
        bus.start = 1'b1;
        chk("ign_busy1", 32'(bus.busy), 1);
        @(negedge clk);
        bus.start = 1'b0;
        chk("ign_busy2", 32'(bus.busy), 1);
        wait_idle();

        // Back-to-back with start held high.
        @(negedge clk);
        bus.A     = 16'h0005;
        bus.B     = 16'h0003;
        bus.Bin   = 1'b0;
        bus.start = 1'b1;
        k1 = cyc + 1;
        x = '{16'h0002, 1'b0, 1'b0, 1'b0, k1 + 4, "bb1"};
        q.push_back(x);
        x = '{16'hFFFE, 1'b1, 1'b0, 1'b1, k1 + 9, "bb2"};
        q.push_back(x);
        @(negedge clk);
        bus.A = 16'h0003;
        bus.B = 16'h0005;
        repeat (5) @(negedge clk);
        bus.start = 1'b0;
        wait_idle();

        // Asynchronous reset in the 3rd RUN cycle.
        issue(16'h5555, 16'h1111, 0, 16'h0, 0, 0, 0, "rr", 0);
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", 32'(bus.busy), 0);
        chk("arst_done", 32'(bus.done), 0);
        chk("arst_D", 32'(bus.D), 0);
        chk("arst_Bout", 32'(bus.Bout), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        issue(16'hABCD, 16'h1234, 0, 16'h9999, 0, 0, 1, "post", 1);
        wait_idle();

        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL leftover_expect count=%0d", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
